// File: rtl/fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_write_arbiter
//
// Shares the single write port of a FIFO between NUM_REQ requesters using
// round-robin arbitration with a bounded burst length. Requesters use a
// valid/ready handshake. The FIFO full flag stalls transfers without losing
// the grant. Data is not registered: the granted requester's word is muxed
// straight onto fifo_wr_data.
//
// Parameters:
//   DATA_WIDTH  width of each requester word and of the FIFO write data
//   NUM_REQ     number of requesters (2..8)
//   BURST_MAX   max consecutive transfers per grant before re-arbitration
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   req_valid     per-requester data valid
//   req_data      packed requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     per-requester ready (transfer on valid & ready)
//   fifo_full     FIFO full flag
//   fifo_wr_en    FIFO write enable
//   fifo_wr_data  word written to the FIFO
//   grant_id      index of the currently granted requester
//   busy          high while a requester holds the grant
//
// Optional feature (macro FIFO_ARB_STATS_EN):
//   stats_clear   clears all transfer counters (wins over a same-cycle increment)
//   xfer_count    NUM_REQ saturating 16-bit transfer counters, requester i at
//                 [i*16 +: 16]
// -----------------------------------------------------------------------------
module fifo_write_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int BURST_MAX  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_wr_data,
   output logic [$clog2(NUM_REQ)-1:0]    grant_id,
   output logic                          busy
`ifdef FIFO_ARB_STATS_EN
   ,
   input  logic                          stats_clear,
   output logic [NUM_REQ*16-1:0]         xfer_count
`endif
);

   localparam int          IDW    = $clog2(NUM_REQ);
   localparam int          BCW    = $clog2(BURST_MAX + 1);
   localparam int unsigned NREQ_U = NUM_REQ;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [IDW-1:0]   grant_id_q, grant_id_d;
   logic [BCW-1:0]   burst_cnt_q, burst_cnt_d;

   logic             win_found;
   logic [IDW-1:0]   win_id;
   logic [IDW-1:0]   cand;
   logic             grant_valid;
   logic             xfer;
   logic             burst_last;
   logic             rel;

   // Round-robin search: scan grant_id+1 .. grant_id (inclusive), wrapping at
   // NUM_REQ rather than 2^IDW so non-power-of-two counts never hit a hole.
   always_comb begin : rr_search
      win_found = 1'b0;
      win_id    = grant_id_q;
      cand      = '0;
      for (int unsigned off = 1; off <= NREQ_U; off++) begin
         cand = IDW'((32'(grant_id_q) + off) % NREQ_U);
         if (!win_found && req_valid[cand]) begin
            win_found = 1'b1;
            win_id    = cand;
         end
      end
   end

   // A transfer is suppressed in the reset cycle even though state is still
   // GRANT, so nothing is written while the block is being reset.
   always_comb begin : xfer_logic
      grant_valid = req_valid[grant_id_q];
      xfer        = (state_q == GRANT) && grant_valid && !fifo_full && !reset;
      burst_last  = (burst_cnt_q == BCW'(BURST_MAX - 1));
      rel         = !grant_valid || (xfer && burst_last);
   end

   always_comb begin : next_state
      state_d     = state_q;
      grant_id_d  = grant_id_q;
      burst_cnt_d = burst_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d     = GRANT;
               grant_id_d  = win_id;
               burst_cnt_d = '0;
            end
         end
         GRANT: begin
            if (rel) begin
               // Hand over directly without an idle bubble; a burst-exhausted
               // requester that is the only one valid simply wins again.
               if (win_found) begin
                  grant_id_d  = win_id;
                  burst_cnt_d = '0;
               end else begin
                  state_d     = IDLE;
                  burst_cnt_d = '0;
               end
            end else if (xfer) begin
               burst_cnt_d = burst_cnt_q + BCW'(1);
            end
         end
         default: begin
            state_d     = IDLE;
            burst_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin : fsm_regs
      if (reset) begin
         state_q     <= IDLE;
         grant_id_q  <= IDW'(NUM_REQ - 1);
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         grant_id_q  <= grant_id_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

   always_comb begin : outputs
      req_ready    = '0;
      fifo_wr_data = '0;
      for (int unsigned i = 0; i < NREQ_U; i++) begin
         if (grant_id_q == IDW'(i)) begin
            req_ready[i] = (state_q == GRANT) && !fifo_full && !reset;
            fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      fifo_wr_en = xfer;
      grant_id   = grant_id_q;
      busy       = (state_q == GRANT);
   end

`ifdef FIFO_ARB_STATS_EN
   logic [15:0] cnt_q [NUM_REQ];

   always_ff @(posedge clk) begin : stats_regs
      if (reset || stats_clear) begin
         for (int unsigned i = 0; i < NREQ_U; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int unsigned i = 0; i < NREQ_U; i++) begin
            if (xfer && (grant_id_q == IDW'(i)) && (cnt_q[i] != '1)) begin
               cnt_q[i] <= cnt_q[i] + 16'd1;
            end
         end
      end
   end

   always_comb begin : stats_pack
      xfer_count = '0;
      for (int unsigned i = 0; i < NREQ_U; i++) begin
         xfer_count[i*16 +: 16] = cnt_q[i];
      end
   end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Directed, self-checking bench for fifo_write_arbiter (DATA_WIDTH=8,
// NUM_REQ=4, BURST_MAX=4). Each scenario task drives stimulus and checks
// outputs inline. Stats scenario is compiled only with FIFO_ARB_STATS_EN.
// -----------------------------------------------------------------------------
module tb_fifo_write_arbiter;

   logic        clk;
   logic        reset;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic        fifo_full;
   logic        fifo_wr_en;
   logic [7:0]  fifo_wr_data;
   logic [1:0]  grant_id;
   logic        busy;
`ifdef FIFO_ARB_STATS_EN
   logic        stats_clear;
   logic [63:0] xfer_count;
`endif

   int checks;
   int failures;

   logic [7:0] exp_data [4];

   fifo_write_arbiter #(
      .DATA_WIDTH(8),
      .NUM_REQ   (4),
      .BURST_MAX (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .fifo_full   (fifo_full),
      .fifo_wr_en  (fifo_wr_en),
      .fifo_wr_data(fifo_wr_data),
      .grant_id    (grant_id),
      .busy        (busy)
`ifdef FIFO_ARB_STATS_EN
      ,
      .stats_clear (stats_clear),
      .xfer_count  (xfer_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; inputs are then driven / outputs sampled 2 ns later.
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      req_valid = 4'b1111;
      fifo_full = 1'b0;
      reset     = 1'b1;
      step();
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=%b", req_ready, 4'b0000); end
      checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", fifo_wr_en); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
      checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL reset_grant got=%0d exp=3", grant_id); end
      reset = 1'b0;
      #1;
      // First cycle after reset is the IDLE arbitration cycle.
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
      checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL idle_wr_en got=%b exp=0", fifo_wr_en); end
      step();
      checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL first_grant got=%0d exp=0", grant_id); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL first_busy got=%b exp=1", busy); end
      checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL first_wr_en got=%b exp=1", fifo_wr_en); end
      checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL first_ready got=%b exp=0001", req_ready); end
      checks++; if (fifo_wr_data !== 8'h11) begin failures++; $display("FAIL first_data got=%h exp=11", fifo_wr_data); end
   endtask

   task automatic test_round_robin();
      logic [3:0] exp_rdy;
      req_valid = 4'b0000;
      do_reset();
      req_valid = 4'b1111;
      step();
      for (int k = 0; k < 16; k++) begin
         exp_rdy = 4'b0001 << (k / 4);
         checks++; if (grant_id !== 2'(k / 4)) begin failures++; $display("FAIL rr_grant cyc=%0d got=%0d exp=%0d", k, grant_id, k / 4); end
         checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL rr_wr_en cyc=%0d got=%b exp=1", k, fifo_wr_en); end
         checks++; if (fifo_wr_data !== exp_data[k / 4]) begin failures++; $display("FAIL rr_data cyc=%0d got=%h exp=%h", k, fifo_wr_data, exp_data[k / 4]); end
         checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_ready cyc=%0d got=%b exp=%b", k, req_ready, exp_rdy); end
         step();
      end
      checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL rr_wrap_grant got=%0d exp=0", grant_id); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rr_wrap_busy got=%b exp=1", busy); end
   endtask

   task automatic test_single_requester();
      int writes;
      writes    = 0;
      req_valid = 4'b0000;
      do_reset();
      req_valid = 4'b0100;
      step();
      for (int k = 0; k < 10; k++) begin
         checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL single_grant cyc=%0d got=%0d exp=2", k, grant_id); end
         checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL single_ready cyc=%0d got=%b exp=0100", k, req_ready); end
         if (fifo_wr_en === 1'b1) writes++;
         step();
      end
      checks++; if (writes !== 10) begin failures++; $display("FAIL single_writes got=%0d exp=10", writes); end
      req_valid = 4'b0000;
      #1;
      checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL single_drop_wr_en got=%b exp=0", fifo_wr_en); end
      step();
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy got=%b exp=0", busy); end
      checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL single_idle_grant got=%0d exp=2", grant_id); end
   endtask

   task automatic test_fifo_full();
      req_valid = 4'b0000;
      fifo_full = 1'b0;
      do_reset();
      req_valid = 4'b0110;
      step();
      for (int k = 0; k < 2; k++) begin
         checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL full_pre_grant cyc=%0d got=%0d exp=1", k, grant_id); end
         checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL full_pre_wr_en cyc=%0d got=%b exp=1", k, fifo_wr_en); end
         step();
      end
      fifo_full = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL full_ready cyc=%0d got=%b exp=0000", k, req_ready); end
         checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL full_wr_en cyc=%0d got=%b exp=0", k, fifo_wr_en); end
         checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL full_grant cyc=%0d got=%0d exp=1", k, grant_id); end
         checks++; if (busy !== 1'b1) begin failures++; $display("FAIL full_busy cyc=%0d got=%b exp=1", k, busy); end
         step();
      end
      fifo_full = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         checks++; if (grant_id !== 2'd1) begin failures++; $display("FAIL full_post_grant cyc=%0d got=%0d exp=1", k, grant_id); end
         checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL full_post_wr_en cyc=%0d got=%b exp=1", k, fifo_wr_en); end
         step();
      end
      // Fourth write completed the burst, so requester 2 now holds the grant.
      checks++; if (grant_id !== 2'd2) begin failures++; $display("FAIL full_next_grant got=%0d exp=2", grant_id); end
      checks++; if (fifo_wr_data !== 8'h33) begin failures++; $display("FAIL full_next_data got=%h exp=33", fifo_wr_data); end
   endtask

   task automatic test_reset_mid_burst();
      req_valid = 4'b0000;
      do_reset();
      req_valid = 4'b1000;
      step();
      for (int k = 0; k < 2; k++) begin
         checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL mid_grant cyc=%0d got=%0d exp=3", k, grant_id); end
         checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL mid_wr_en cyc=%0d got=%b exp=1", k, fifo_wr_en); end
         step();
      end
      reset     = 1'b1;
      req_valid = 4'b1001;
      #1;
      checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL mid_rst_wr_en got=%b exp=0", fifo_wr_en); end
      checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0000", req_ready); end
      step();
      reset = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_idle_busy got=%b exp=0", busy); end
      checks++; if (grant_id !== 2'd3) begin failures++; $display("FAIL mid_idle_grant got=%0d exp=3", grant_id); end
      checks++; if (fifo_wr_en !== 1'b0) begin failures++; $display("FAIL mid_idle_wr_en got=%b exp=0", fifo_wr_en); end
      step();
      checks++; if (grant_id !== 2'd0) begin failures++; $display("FAIL mid_regrant got=%0d exp=0", grant_id); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL mid_regrant_busy got=%b exp=1", busy); end
      checks++; if (fifo_wr_data !== 8'h11) begin failures++; $display("FAIL mid_regrant_data got=%h exp=11", fifo_wr_data); end
   endtask

`ifdef FIFO_ARB_STATS_EN
   task automatic test_stats();
      req_valid   = 4'b0000;
      stats_clear = 1'b0;
      do_reset();
      req_valid = 4'b0001;
      step();
      repeat (5) step();
      checks++; if (xfer_count[15:0] !== 16'd5) begin failures++; $display("FAIL stats_count5 got=%0d exp=5", xfer_count[15:0]); end
      repeat (69995) step();
      checks++; if (xfer_count[15:0] !== 16'hFFFF) begin failures++; $display("FAIL stats_sat got=%h exp=ffff", xfer_count[15:0]); end
      checks++; if (xfer_count[63:16] !== 48'd0) begin failures++; $display("FAIL stats_others got=%h exp=0", xfer_count[63:16]); end
      stats_clear = 1'b1;
      #1;
      checks++; if (fifo_wr_en !== 1'b1) begin failures++; $display("FAIL stats_clr_wr_en got=%b exp=1", fifo_wr_en); end
      step();
      stats_clear = 1'b0;
      #1;
      checks++; if (xfer_count[15:0] !== 16'd0) begin failures++; $display("FAIL stats_clear got=%0d exp=0", xfer_count[15:0]); end
      step();
      checks++; if (xfer_count[15:0] !== 16'd1) begin failures++; $display("FAIL stats_after_clear got=%0d exp=1", xfer_count[15:0]); end
   endtask
`endif

   initial begin
      checks      = 0;
      failures    = 0;
      exp_data    = '{8'h11, 8'h22, 8'h33, 8'h44};
      reset       = 1'b1;
      req_valid   = 4'b0000;
      req_data    = {8'h44, 8'h33, 8'h22, 8'h11};
      fifo_full   = 1'b0;
`ifdef FIFO_ARB_STATS_EN
      stats_clear = 1'b0;
`endif
      step();
      test_reset();
      test_round_robin();
      test_single_requester();
      test_fifo_full();
      test_reset_mid_burst();
`ifdef FIFO_ARB_STATS_EN
      test_stats();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
